// File: rtl/grant_decoder_pkg.sv
// Shared definitions for the grant return path: FSM encoding and the one-hot decode rule.
// The decode rule is shared by the Out load and by the Ack[idx] selection.
package grant_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StDrain = 2'b10
    } state_e;

    // Bit 'pos' of the one-hot code for 'idx'. An out-of-range index decodes to all-zero.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned n,
                                        input int unsigned pos);
        return (idx < n) && (idx == pos);
    endfunction

endpackage

// File: rtl/grant_decoder_onehot.sv
// Combinational index-to-one-hot decoder (onehot_decoder). The output is all-zero when
// idx >= N, which only happens when N is not a power of two.
module onehot_decoder
    import grant_decoder_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic [AW-1:0] idx,
    output logic [N-1:0]  sel
);

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel[i] = onehot_bit(32'(idx), N, i);
        end
    end

endmodule

// File: rtl/grant_decoder.sv
// Registered one-hot grant driver. It holds a grant until the selected line acknowledges
// or the hold timer expires, then drains until that line drops its Ack.
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter  int unsigned N       = 4,
    parameter  int unsigned TIMEOUT = 15,
    localparam int unsigned AW      = $clog2(N),
    localparam int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] in,
    input  logic          valid,
    input  logic [N-1:0]  ack,
    output logic [N-1:0]  out,
    output logic          ready,
    output logic          busy,
    output logic          err,
    output logic          timeout
);

    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  out_q, out_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;

    logic [N-1:0]  load_sel;
    logic [N-1:0]  ack_sel;
    logic          ack_hit;

    onehot_decoder #(
        .N (N)
    ) u_load_dec (
        .idx (in),
        .sel (load_sel)
    );

    onehot_decoder #(
        .N (N)
    ) u_ack_dec (
        .idx (idx_q),
        .sel (ack_sel)
    );

    // Only the granted line's Ack matters; every other Ack bit is masked off here.
    assign ack_hit = |(ack & ack_sel);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (valid) begin
                    if (|load_sel) begin
                        idx_d   = in;
                        out_d   = load_sel;
                        cnt_d   = '0;
                        state_d = StGrant;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGrant: begin
                // Ack takes precedence over a timeout landing on the same edge.
                if (ack_hit) begin
                    out_d   = '0;
                    state_d = StDrain;
                end else if (cnt_q == CntLast) begin
                    out_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrain: begin
                out_d = '0;
                if (!ack_hit) begin
                    state_d = StIdle;
                end
            end
            default: begin
                out_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign out     = out_q;
    assign ready   = (state_q == StIdle);
    assign busy    = (state_q != StIdle);
    assign err     = err_q;
    assign timeout = tmo_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: directed scenarios on N=4 and N=5 instances plus a randomized run
// against a cycle-level behavioural model of the grant/hold/drain rules.
module tb_grant_decoder;

    localparam int unsigned N  = 4;
    localparam int unsigned T  = 8;
    localparam int unsigned NB = 5;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [1:0] in_a;
    logic       valid_a;
    logic [3:0] ack_a;
    logic [3:0] out_a;
    logic       ready_a, busy_a, err_a, tmo_a;

    logic [2:0] in_b;
    logic       valid_b;
    logic [4:0] ack_b;
    logic [4:0] out_b;
    logic       ready_b, busy_b, err_b, tmo_b;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 = idle, 1 = holding a grant, 2 = waiting for Ack to drop.
    int         m_st;
    int         m_line;
    int         m_age;
    logic       m_tmo;
    logic [3:0] exp_out;

    grant_decoder #(
        .N       (N),
        .TIMEOUT (T)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_a),
        .valid   (valid_a),
        .ack     (ack_a),
        .out     (out_a),
        .ready   (ready_a),
        .busy    (busy_a),
        .err     (err_a),
        .timeout (tmo_a)
    );

    grant_decoder #(
        .N       (NB),
        .TIMEOUT (T)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_b),
        .valid   (valid_b),
        .ack     (ack_b),
        .out     (out_b),
        .ready   (ready_b),
        .busy    (busy_b),
        .err     (err_b),
        .timeout (tmo_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st   = 0;
        m_line = 0;
        m_age  = 0;
        m_tmo  = 1'b0;
    endtask

    // Advances the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        m_tmo = 1'b0;
        case (m_st)
            0: if (valid_a && int'(in_a) < N) begin
                m_line = int'(in_a);
                m_age  = 0;
                m_st   = 1;
            end
            1: begin
                m_age++;
                if (ack_a[m_line]) begin
                    m_st = 2;
                end else if (m_age == T) begin
                    m_st  = 2;
                    m_tmo = 1'b1;
                end
            end
            default: if (!ack_a[m_line]) m_st = 0;
        endcase
    endtask

    // One clock: edge, model update, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        in_a    = '0;
        valid_a = 1'b0;
        ack_a   = '0;
        in_b    = '0;
        valid_b = 1'b0;
        ack_b   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (out_a !== 4'b0 || ready_a !== 1'b1 || busy_a !== 1'b0 || err_a !== 1'b0 ||
            tmo_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: out=%b ready=%b busy=%b err=%b tmo=%b, want 0000 1 0 0 0",
                     out_a, ready_a, busy_a, err_a, tmo_a);
        end
        n_vec++;
        if (out_b !== 5'b0 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: out=%b ready=%b busy=%b, want 00000 1 0",
                     out_b, ready_b, busy_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ack_release();
        in_a    = 2'd2;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_vec++;
        if (out_a !== 4'b0100 || ready_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL ack_grant: out=%b ready=%b busy=%b, want 0100 0 1",
                     out_a, ready_a, busy_a);
        end
        ack_a = 4'b0100;
        tick();
        n_vec++;
        if (out_a !== 4'b0000 || ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL ack_drop: out=%b ready=%b, want 0000 0", out_a, ready_a);
        end
        tick();
        ack_a = 4'b0000;
        n_vec++;
        if (ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL ack_drain_hold: ready=%b, want 0", ready_a);
        end
        tick();
        n_vec++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle: ready=%b busy=%b, want 1 0", ready_a, busy_a);
        end
    endtask

    task automatic test_timeout();
        in_a    = 2'd1;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < int'(T); i++) begin
            n_vec++;
            if (out_a !== 4'b0010 || tmo_a !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_hold[%0d]: out=%b tmo=%b, want 0010 0", i, out_a, tmo_a);
            end
            tick();
        end
        n_vec++;
        if (out_a !== 4'b0000 || tmo_a !== 1'b1 || ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_release: out=%b tmo=%b ready=%b, want 0000 1 0",
                     out_a, tmo_a, ready_a);
        end
        tick();
        n_vec++;
        if (tmo_a !== 1'b0 || ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_after: tmo=%b ready=%b, want 0 1", tmo_a, ready_a);
        end
    endtask

    task automatic test_ack_at_limit();
        in_a    = 2'd1;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        repeat (T - 1) tick();
        n_vec++;
        if (out_a !== 4'b0010) begin
            n_err++;
            $display("FAIL limit_hold: out=%b, want 0010", out_a);
        end
        ack_a = 4'b0010;
        tick();
        n_vec++;
        if (out_a !== 4'b0000 || tmo_a !== 1'b0 || ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL limit_ack_wins: out=%b tmo=%b ready=%b, want 0000 0 0",
                     out_a, tmo_a, ready_a);
        end
        ack_a = 4'b0000;
        tick();
        n_vec++;
        if (ready_a !== 1'b1 || tmo_a !== 1'b0) begin
            n_err++;
            $display("FAIL limit_idle: ready=%b tmo=%b, want 1 0", ready_a, tmo_a);
        end
    endtask

    task automatic test_ignore_other();
        in_a    = 2'd3;
        valid_a = 1'b1;
        tick();
        ack_a   = 4'b0001;
        in_a    = 2'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (out_a !== 4'b1000 || err_a !== 1'b0 || ready_a !== 1'b0) begin
                n_err++;
                $display("FAIL ignore[%0d]: out=%b err=%b ready=%b, want 1000 0 0",
                         i, out_a, err_a, ready_a);
            end
        end
        valid_a = 1'b0;
        ack_a   = 4'b1000;
        tick();
        ack_a   = 4'b0000;
        tick();
        n_vec++;
        if (ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_idle: ready=%b, want 1", ready_a);
        end
    endtask

    task automatic test_err_n5();
        in_b    = 3'd6;
        valid_b = 1'b1;
        tick();
        n_vec++;
        if (err_b !== 1'b1 || out_b !== 5'b00000 || ready_b !== 1'b1) begin
            n_err++;
            $display("FAIL err_pulse: err=%b out=%b ready=%b, want 1 00000 1",
                     err_b, out_b, ready_b);
        end
        in_b = 3'd4;
        tick();
        valid_b = 1'b0;
        n_vec++;
        if (err_b !== 1'b0 || out_b !== 5'b10000 || ready_b !== 1'b0) begin
            n_err++;
            $display("FAIL err_then_grant: err=%b out=%b ready=%b, want 0 10000 0",
                     err_b, out_b, ready_b);
        end
        ack_b = 5'b10000;
        tick();
        ack_b = 5'b00000;
        tick();
        n_vec++;
        if (ready_b !== 1'b1 || out_b !== 5'b00000) begin
            n_err++;
            $display("FAIL err_idle: ready=%b out=%b, want 1 00000", ready_b, out_b);
        end
    endtask

    task automatic test_reset_mid();
        in_a    = 2'd2;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (out_a !== 4'b0000 || tmo_a !== 1'b0 || err_a !== 1'b0 || ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL midrst: out=%b tmo=%b err=%b ready=%b, want 0000 0 0 1",
                     out_a, tmo_a, err_a, ready_a);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        in_a    = 2'd0;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_vec++;
        if (out_a !== 4'b0001 || ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_next: out=%b ready=%b, want 0001 0", out_a, ready_a);
        end
        ack_a = 4'b0001;
        tick();
        ack_a = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            valid_a = ($urandom_range(0, 1) == 1);
            in_a    = 2'($urandom_range(0, 3));
            ack_a   = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
            exp_out = (m_st == 1) ? (4'b0001 << m_line) : 4'b0000;
            n_vec++;
            if (out_a !== exp_out || ready_a !== (m_st == 0) || busy_a !== (m_st != 0) ||
                tmo_a !== m_tmo || err_a !== 1'b0) begin
                n_err++;
                $display("FAIL rand[%0d]: out=%b ready=%b busy=%b tmo=%b err=%b, want %b %b %b %b 0",
                         i, out_a, ready_a, busy_a, tmo_a, err_a, exp_out, (m_st == 0),
                         (m_st != 0), m_tmo);
            end
        end
        valid_a = 1'b0;
        ack_a   = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_ack_release();
        test_timeout();
        test_ack_at_limit();
        test_ignore_other();
        test_err_n5();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
